// File: rtl/reverse_sched_pkg.sv
// reverse_sched_pkg: shared types and defaults for the reverse_sched slice.
//   state_e        : scheduler FSM states
//   *_DEF          : default parameter values for the scheduler
//   IDX_W_DEF      : client index width for the default client count
package reverse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2,
        ABORT   = 2'd3
    } state_e;

    localparam int N_REQ_DEF       = 4;
    localparam int DATA_W_DEF      = 16;
    localparam int TIMEOUT_CYC_DEF = 256;
    localparam int IDX_W_DEF       = $clog2(N_REQ_DEF);

endpackage

// File: rtl/reverse_sched_if.sv
// reverse_sched_if: client and engine signals of the reverse scheduler.
//   req/x_in          : client request levels and packed operands
//   gnt/ack/err/result: grant, completion pulse, abort flag, reversed value
//   eng_start/eng_x   : start level and operand towards the engine
//   eng_done/eng_result: engine Done level and output value
// Modports: slave = scheduler view, master = clients + engine view.
interface reverse_sched_if
    import reverse_sched_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] x_in;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic                    err;
    logic [DATA_W-1:0]       result;
    logic                    eng_start;
    logic [DATA_W-1:0]       eng_x;
    logic                    eng_done;
    logic [DATA_W-1:0]       eng_result;

    modport slave (
        input  req, x_in, eng_done, eng_result,
        output gnt, ack, err, result, eng_start, eng_x
    );

    modport master (
        output req, x_in, eng_done, eng_result,
        input  gnt, ack, err, result, eng_start, eng_x
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index
//   found : any request asserted
//   idx   : first asserted index searching ptr, ptr+1, ... mod N_REQ
module rr_pick
    import reverse_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/reverse_sched.sv
// reverse_sched: round-robin sharing of one digit-reverse engine among
// N_REQ clients, with a watchdog that aborts a hung engine.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : reverse_sched_if.slave (client req/x_in/gnt/ack/err/result,
//              engine eng_start/eng_x/eng_done/eng_result)
// All outputs are registered.
module reverse_sched
    import reverse_sched_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    reverse_sched_if.slave  bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);

    state_e            state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;
    logic [N_REQ-1:0]  gnt, gnt_nxt;
    logic [N_REQ-1:0]  ack, ack_nxt;
    logic              err, err_nxt;
    logic              eng_start, eng_start_nxt;
    logic [DATA_W-1:0] result, result_nxt;
    logic [DATA_W-1:0] eng_x, eng_x_nxt;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              wd_last;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Watchdog has counted the full RUN budget on this cycle.
    assign wd_last = (wd == WD_W'(TIMEOUT_CYC - 1));

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            wd        <= '0;
            gnt       <= '0;
            ack       <= '0;
            err       <= 1'b0;
            eng_start <= 1'b0;
            result    <= '0;
            eng_x     <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            idx       <= idx_nxt;
            wd        <= wd_nxt;
            gnt       <= gnt_nxt;
            ack       <= ack_nxt;
            err       <= err_nxt;
            eng_start <= eng_start_nxt;
            result    <= result_nxt;
            eng_x     <= eng_x_nxt;
        end
    end

    // Next state; eng_done takes priority over the watchdog in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:          if (pick_found)    state_nxt = RUN;
            RUN:           if (bus.eng_done)  state_nxt = RELEASE;
                           else if (wd_last)  state_nxt = ABORT;
            RELEASE,
            ABORT:         if (!bus.eng_done) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Next output/datapath values; ack and err are single-cycle pulses.
    always_comb begin
        ptr_nxt       = ptr;
        idx_nxt       = idx;
        wd_nxt        = wd;
        gnt_nxt       = gnt;
        ack_nxt       = '0;
        err_nxt       = 1'b0;
        eng_start_nxt = eng_start;
        result_nxt    = result;
        eng_x_nxt     = eng_x;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    idx_nxt       = pick_idx;
                    eng_x_nxt     = bus.x_in[pick_idx*DATA_W +: DATA_W];
                    gnt_nxt       = N_REQ'(1) << pick_idx;
                    eng_start_nxt = 1'b1;
                    wd_nxt        = '0;
                end
            end
            RUN: begin
                if (bus.eng_done) begin
                    eng_start_nxt = 1'b0;
                    ack_nxt       = gnt;
                    result_nxt    = bus.eng_result;
                end else if (wd_last) begin
                    eng_start_nxt = 1'b0;
                    ack_nxt       = gnt;
                    err_nxt       = 1'b1;
                    result_nxt    = '0;
                end else begin
                    wd_nxt = wd + 1'b1;
                end
            end
            RELEASE, ABORT: begin
                // Hold the grant until the engine has dropped Done.
                if (!bus.eng_done) begin
                    gnt_nxt = '0;
                    ptr_nxt = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
                    wd_nxt  = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt       = gnt;
    assign bus.ack       = ack;
    assign bus.err       = err;
    assign bus.result    = result;
    assign bus.eng_start = eng_start;
    assign bus.eng_x     = eng_x;

endmodule
